wb_drain_ctrl: RTL and testbench

Drain side of the write-back buffer. Pops the head entry whenever the buffer is non-empty, aligns the store onto a 32-bit word memory write port, and splits any word-crossing store into two transactions. Completes each transaction via a req/ack handshake and reports retirement of the last store uop of an instruction by EIP. Sits between the write-back buffer's dequeue port and the data-memory write port.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_lane_align.sv | 30 +++
 rtl/wb_drain_ctrl.sv | 161 ++++++++++++++++
 tb/tb_wb_drain_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back buffer drain path.
// Holds size codes, default widths and the drain FSM state encoding.
package wb_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int EIP_W_DEF  = 32;

    localparam logic [2:0] SZ_1B = 3'd0;
    localparam logic [2:0] SZ_2B = 3'd1;
    localparam logic [2:0] SZ_4B = 3'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_LO = 2'd1,
        REQ_HI = 2'd2
    } drain_state_t;

    // Byte mask for a store of the given size code, before lane shifting.
    // Any code that is not 1 or 2 bytes is treated as a full word.
    function automatic logic [3:0] size_mask(input logic [2:0] size);
        case (size)
            SZ_1B:   size_mask = 4'h1;
            SZ_2B:   size_mask = 4'h3;
            SZ_4B:   size_mask = 4'hF;
            default: size_mask = 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Lane alignment of an LSB-justified store onto two consecutive 32-bit words.
// The lo beat covers the addressed word, the hi beat the word after it.
module wb_lane_align
    import wb_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic [31:0] data,
    output logic [3:0]  lo_be,
    output logic [3:0]  hi_be,
    output logic [31:0] lo_wdata,
    output logic [31:0] hi_wdata,
    output logic        split
);

    logic [7:0]  mask8;
    logic [63:0] data64;

    // Shift mask and data into a 64-bit window, then slice into the two beats.
    always_comb begin
        mask8    = {4'b0000, size_mask(size)} << off;
        data64   = {32'b0, data} << {off, 3'b000};
        lo_be    = mask8[3:0];
        hi_be    = mask8[7:4];
        lo_wdata = data64[31:0];
        hi_wdata = data64[63:32];
        split    = |mask8[7:4];
    end

endmodule

// File: rtl/wb_drain_ctrl.sv
// Drain side of the write-back buffer: pops entries, writes them to the
// word-wide memory port (one or two beats) and reports instruction retirement.
// Optional build macro WB_DRAIN_STAT_EN adds drained/split/squash counters.
//
// state  | meaning
// IDLE   | nothing in flight; pop whenever the buffer is non-empty
// REQ_LO | requesting the beat for the addressed word
// REQ_HI | requesting the beat for the following word (split stores only)
module wb_drain_ctrl
    import wb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int EIP_W  = EIP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_empty,
    input  logic              wb_vld,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [31:0]       wb_data,
    input  logic [EIP_W-1:0]  wb_eip,
    input  logic [2:0]        wb_size,
    input  logic              wb_last_uop,
    output logic              wb_read,
    output logic              mem_req,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              o_done_vld,
    output logic [EIP_W-1:0]  o_done_eip,
    output logic              o_busy
`ifdef WB_DRAIN_STAT_EN
    ,
    output logic [31:0]       stat_drained,
    output logic [31:0]       stat_split,
    output logic [31:0]       stat_squash
`endif
);

    drain_state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [EIP_W-1:0]  eip_q;
    logic [2:0]        size_q;
    logic              last_q;

    logic [3:0]        lo_be, hi_be;
    logic [31:0]       lo_wdata, hi_wdata;
    logic              split;
    logic [ADDR_W-3:0] word_lo, word_hi;
    logic              final_ack;
    logic              pop_vld;

    wb_lane_align u_align (
        .off      (addr_q[1:0]),
        .size     (size_q),
        .data     (data_q),
        .lo_be    (lo_be),
        .hi_be    (hi_be),
        .lo_wdata (lo_wdata),
        .hi_wdata (hi_wdata),
        .split    (split)
    );

    assign word_lo = addr_q[ADDR_W-1:2];
    assign word_hi = word_lo + (ADDR_W-2)'(1);

    // Pop decision, next state and memory port drive.
    always_comb begin
        final_ack = 1'b0;
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;

        case (state_q)
            REQ_LO:  final_ack = mem_ack && !split;
            REQ_HI:  final_ack = mem_ack;
            default: final_ack = 1'b0;
        endcase

        wb_read = !rst && !wb_empty && (state_q == IDLE || final_ack);
        pop_vld = wb_read && wb_vld;

        case (state_q)
            IDLE: begin
                if (pop_vld) state_d = REQ_LO;
            end
            REQ_LO: begin
                mem_req   = 1'b1;
                mem_addr  = word_lo;
                mem_be    = lo_be;
                mem_wdata = lo_wdata;
                if (mem_ack) state_d = split ? REQ_HI : (pop_vld ? REQ_LO : IDLE);
            end
            REQ_HI: begin
                mem_req   = 1'b1;
                mem_addr  = word_hi;
                mem_be    = hi_be;
                mem_wdata = hi_wdata;
                if (mem_ack) state_d = pop_vld ? REQ_LO : IDLE;
            end
            default: state_d = IDLE;
        endcase

        o_busy = (state_q != IDLE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Latch the head entry on a valid pop; squashed entries are never captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
            eip_q  <= '0;
            size_q <= '0;
            last_q <= 1'b0;
        end else if (pop_vld) begin
            addr_q <= wb_addr;
            data_q <= wb_data;
            eip_q  <= wb_eip;
            size_q <= wb_size;
            last_q <= wb_last_uop;
        end
    end

    // One-cycle retire pulse after the final beat of a last-uop store.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_done_vld <= 1'b0;
            o_done_eip <= '0;
        end else begin
            o_done_vld <= final_ack && last_q;
            if (final_ack && last_q) o_done_eip <= eip_q;
        end
    end

`ifdef WB_DRAIN_STAT_EN
    // Event counters; free-running and wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_drained <= '0;
            stat_split   <= '0;
            stat_squash  <= '0;
        end else begin
            if (final_ack)                       stat_drained <= stat_drained + 32'd1;
            if (final_ack && state_q == REQ_HI)  stat_split   <= stat_split + 32'd1;
            if (wb_read && !wb_vld)              stat_squash  <= stat_squash + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_drain_ctrl.sv
// Scoreboard bench for wb_drain_ctrl: a model buffer feeds entries, expected
// memory beats and retire EIPs are queued, and a monitor checks them.
module tb_wb_drain_ctrl;

    localparam int AW = 15;
    localparam int EW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_empty, wb_vld, wb_last_uop;
    logic [AW-1:0] wb_addr;
    logic [31:0]   wb_data;
    logic [EW-1:0] wb_eip;
    logic [2:0]    wb_size;
    logic          wb_read, mem_req, mem_ack, o_done_vld, o_busy;
    logic [AW-3:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [EW-1:0] o_done_eip;
`ifdef WB_DRAIN_STAT_EN
    logic [31:0]   stat_drained, stat_split, stat_squash;
`endif

    wb_drain_ctrl #(.ADDR_W(AW), .EIP_W(EW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_empty    (wb_empty),
        .wb_vld      (wb_vld),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_eip      (wb_eip),
        .wb_size     (wb_size),
        .wb_last_uop (wb_last_uop),
        .wb_read     (wb_read),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .o_done_vld  (o_done_vld),
        .o_done_eip  (o_done_eip),
        .o_busy      (o_busy)
`ifdef WB_DRAIN_STAT_EN
        ,
        .stat_drained(stat_drained),
        .stat_split  (stat_split),
        .stat_squash (stat_squash)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          vld;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [EW-1:0] eip;
        logic [2:0]    size;
        logic          last;
    } ent_t;

    typedef struct {
        logic [AW-3:0] addr;
        logic [3:0]    be;
        logic [31:0]   wdata;
    } beat_t;

    ent_t          fifo[$];
    beat_t         exp_mem[$];
    logic [EW-1:0] exp_done[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rd_cnt = 0;
    int pop_cyc = 0;
    int req_cyc = -1;
    int last_beat_cyc = -10;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ent(input logic vld, input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [EW-1:0] eip, input logic [2:0] size, input logic last);
        ent_t e;
        e.vld = vld; e.addr = addr; e.data = data; e.eip = eip; e.size = size; e.last = last;
        fifo.push_back(e);
    endtask

    task automatic exp_beat(input logic [AW-3:0] a, input logic [3:0] be, input logic [31:0] wd);
        beat_t b;
        b.addr = a; b.be = be; b.wdata = wd;
        exp_mem.push_back(b);
    endtask

    // Model buffer: pop on wb_read, then present the new head.
    always @(posedge clk) begin
        cyc++;
        if (wb_read === 1'b1) begin
            rd_cnt++;
            pop_cyc = cyc;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        #2;
        if (fifo.size() == 0) begin
            wb_empty = 1'b1; wb_vld = 1'b0; wb_addr = '0; wb_data = '0;
            wb_eip = '0; wb_size = '0; wb_last_uop = 1'b0;
        end else begin
            wb_empty = 1'b0; wb_vld = fifo[0].vld; wb_addr = fifo[0].addr;
            wb_data = fifo[0].data; wb_eip = fifo[0].eip; wb_size = fifo[0].size;
            wb_last_uop = fifo[0].last;
        end
    end

    // Monitor: retire pulses, accepted beats and payload stability under backpressure.
    logic          req_p = 1'b0, ack_p = 1'b0, rst_p = 1'b1;
    logic [AW-3:0] addr_p;
    logic [3:0]    be_p;
    logic [31:0]   wdata_p;
    beat_t         mb;

    always @(negedge clk) begin
        if (o_done_vld === 1'b1) begin
            if (exp_done.size() == 0) begin
                total++; bad++;
                $display("FAIL done_unexpected: got eip %0h expected no pulse", o_done_eip);
            end else begin
                check("done_eip", o_done_eip, exp_done.pop_front());
                check("done_timing", cyc, last_beat_cyc + 1);
            end
        end
        if (mem_req === 1'b1 && req_p !== 1'b1) req_cyc = cyc;
        if (req_p && !ack_p && !rst && !rst_p) begin
            check("hold_req", mem_req, 1);
            check("hold_addr", mem_addr, addr_p);
            check("hold_be", mem_be, be_p);
            check("hold_wdata", mem_wdata, wdata_p);
        end
        if (mem_req === 1'b1 && mem_ack === 1'b1) begin
            if (exp_mem.size() == 0) begin
                total++; bad++;
                $display("FAIL beat_unexpected: got addr %0h be %0h wdata %0h expected none",
                         mem_addr, mem_be, mem_wdata);
            end else begin
                mb = exp_mem.pop_front();
                check("beat_addr", mem_addr, mb.addr);
                check("beat_be", mem_be, mb.be);
                check("beat_wdata", mem_wdata, mb.wdata);
            end
            last_beat_cyc = cyc;
        end
        req_p = mem_req; ack_p = mem_ack; rst_p = rst;
        addr_p = mem_addr; be_p = mem_be; wdata_p = mem_wdata;
    end

    task automatic drain(input string name, input int max);
        int n = 0;
        while (!(fifo.size() == 0 && exp_mem.size() == 0 && exp_done.size() == 0 && o_busy === 1'b0)) begin
            @(negedge clk);
            n++;
            if (n > max) begin
                total++; bad++;
                $display("FAIL %s_timeout: got %0d beats and %0d retires outstanding expected 0",
                         name, exp_mem.size(), exp_done.size());
                exp_mem.delete(); exp_done.delete();
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    int rd0, run, max_run, busy_seen, n;

    initial begin
        rst = 1'b1; mem_ack = 1'b1;
        wb_empty = 1'b1; wb_vld = 1'b0; wb_addr = '0; wb_data = '0;
        wb_eip = '0; wb_size = '0; wb_last_uop = 1'b0;
        step; step;

        // Reset state, with an entry already waiting in the buffer.
        push_ent(1'b1, 15'h1234, 32'h0CBE6783, 32'h04766387, 3'd3, 1'b1);
        exp_beat(13'h48D, 4'hF, 32'h0CBE6783);
        exp_done.push_back(32'h04766387);
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_done_vld", o_done_vld, 0);
        check("rst_done_eip", o_done_eip, 0);
        check("rst_busy", o_busy, 0);
        check("rst_wb_read", wb_read, 0);
        rd0 = rd_cnt;
        step; rst = 1'b0;

        // 1: aligned store
        drain("t1", 20);
        check("t1_reads", rd_cnt - rd0, 1);
        check("t1_req_latency", req_cyc, pop_cyc);

        // 2: unaligned store, split into two beats
        rd0 = rd_cnt; step;
        push_ent(1'b1, 15'h1236, 32'h0CBE6C83, 32'h00005A10, 3'd3, 1'b1);
        exp_beat(13'h48D, 4'hC, 32'h6C830000);
        exp_beat(13'h48E, 4'h3, 32'h00000CBE);
        exp_done.push_back(32'h00005A10);
        drain("t2", 20);
        check("t2_reads", rd_cnt - rd0, 1);

        // 3: squashed entry
        rd0 = rd_cnt; busy_seen = 0; step;
        push_ent(1'b0, 15'h1236, 32'h0CBE6C83, 32'h00005A20, 3'd3, 1'b1);
        repeat (6) begin
            @(negedge clk);
            if (o_busy !== 1'b0) busy_seen = 1;
        end
        check("t3_reads", rd_cnt - rd0, 1);
        check("t3_busy", busy_seen, 0);

        // 4: backpressure with two entries queued
        rd0 = rd_cnt; step;
        mem_ack = 1'b0;
        push_ent(1'b1, 15'h0100, 32'h11111111, 32'h00000100, 3'd3, 1'b0);
        push_ent(1'b1, 15'h0104, 32'h000000A5, 32'h00000104, 3'd0, 1'b1);
        exp_beat(13'h040, 4'hF, 32'h11111111);
        exp_beat(13'h041, 4'h1, 32'h000000A5);
        exp_done.push_back(32'h00000104);
        repeat (6) @(negedge clk);
        check("t4_reads_stalled", rd_cnt - rd0, 1);
        check("t4_req_stalled", mem_req, 1);
        check("t4_addr_stalled", mem_addr, 13'h040);
        step; mem_ack = 1'b1;
        drain("t4", 20);
        check("t4_reads", rd_cnt - rd0, 2);

        // 5: address wrap, then back-to-back aligned entries
        rd0 = rd_cnt; step;
        push_ent(1'b1, 15'h7FFF, 32'h0000ABCD, 32'h00007FF0, 3'd1, 1'b1);
        exp_beat(13'h1FFF, 4'h8, 32'hCD000000);
        exp_beat(13'h0000, 4'h1, 32'h000000AB);
        exp_done.push_back(32'h00007FF0);
        drain("t5_wrap", 20);
        step;
        push_ent(1'b1, 15'h0010, 32'h00000001, 32'h00000010, 3'd3, 1'b0);
        push_ent(1'b1, 15'h0014, 32'h00000002, 32'h00000014, 3'd3, 1'b0);
        push_ent(1'b1, 15'h0018, 32'h00000003, 32'h00000018, 3'd3, 1'b0);
        exp_beat(13'h004, 4'hF, 32'h00000001);
        exp_beat(13'h005, 4'hF, 32'h00000002);
        exp_beat(13'h006, 4'hF, 32'h00000003);
        run = 0; max_run = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_ack === 1'b1) begin
                run++;
                if (run > max_run) max_run = run;
            end else if (run > 0) begin
                break;
            end
        end
        check("t5_b2b_run", max_run, 3);
        drain("t5_b2b", 20);
        check("t5_reads", rd_cnt - rd0, 4);

        // 6: reset while the hi beat is pending
        rd0 = rd_cnt; step;
        mem_ack = 1'b0;
        push_ent(1'b1, 15'h0002, 32'h12345678, 32'h00000666, 3'd3, 1'b1);
        exp_beat(13'h000, 4'hC, 32'h56780000);
        n = 0;
        while (mem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t6_req_seen", mem_req, 1);
        step; mem_ack = 1'b1;
        step; mem_ack = 1'b0;
        @(negedge clk);
        check("t6_in_hi_be", mem_be, 4'h3);
        check("t6_in_hi_addr", mem_addr, 13'h001);
        step; rst = 1'b1;
        push_ent(1'b1, 15'h0200, 32'hDEADBEEF, 32'h00000600, 3'd3, 1'b1);
        @(negedge clk);
        check("t6_rst_wb_read", wb_read, 0);
        step; rst = 1'b0;
        @(negedge clk);
        check("t6_post_rst_req", mem_req, 0);
        check("t6_post_rst_done", o_done_vld, 0);
        check("t6_post_rst_busy", o_busy, 0);
        exp_beat(13'h080, 4'hF, 32'hDEADBEEF);
        exp_done.push_back(32'h00000600);
        step; mem_ack = 1'b1;
        drain("t6", 20);
        check("t6_reads", rd_cnt - rd0, 2);

        check("final_mem_queue", exp_mem.size(), 0);
        check("final_done_queue", exp_done.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by %0t expected finish", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
